// File: rtl/aoi_pipe.sv
// aoi_pipe: valid/ready pipeline that evaluates a bitwise AND-OR-INVERT
// family function (AOI22 / OAI22 / AO22 / OA22) selected by mode.
//
// The result is computed once, when a transaction is captured into stage 0.
// The stages after it only carry the result forward.
//
// Each stage loads when it is empty or when its contents move forward in the
// same cycle. So bubbles compress behind a stalled output, and a full pipe
// with out_ready high streams one transaction per cycle.
//
// Optional feature: define AOI_PIPE_CNT_EN to add the 16-bit saturating
// completed-transaction counter on port txn_cnt.
//
// Parameters:
//   WIDTH  - operand / result width
//   STAGES - register stages between input and output (1..4)

module aoi_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready
`ifdef AOI_PIPE_CNT_EN
  ,
  output logic [15:0]      txn_cnt
`endif
);

  localparam int LAST = STAGES - 1;

  // Function select encoding
  localparam logic [1:0] MODE_AOI22 = 2'b00;
  localparam logic [1:0] MODE_OAI22 = 2'b01;
  localparam logic [1:0] MODE_AO22  = 2'b10;
  localparam logic [1:0] MODE_OA22  = 2'b11;

  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  dat [STAGES];
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  func;

  logic              in_xfer;
  logic              out_xfer;

  // Bitwise function evaluation on the incoming operands
  always_comb begin
    func = '0;
    case (mode)
      MODE_AOI22: func = ~((a & b) | (c & d));
      MODE_OAI22: func = ~((a | b) & (c | d));
      MODE_AO22:  func = (a & b) | (c & d);
      MODE_OA22:  func = (a | b) & (c | d);
      default:    func = '0;
    endcase
  end

  // Ready chain: a stage may load when it is empty or its contents leave
  // this cycle. It is built from the output back toward the input, and a
  // scalar running term keeps the chain acyclic.
  always_comb begin
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int i = LAST; i >= 0; i--) begin
      r      = !vld[i] || r;
      rdy[i] = r;
    end
  end

  // in_ready is held low while reset is asserted. The reset is synchronous,
  // so the valid bits alone would not force it low.
  assign in_ready  = rst_n && rdy[0];
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = vld[LAST];
  assign y         = dat[LAST];
  assign out_xfer  = out_valid && out_ready;

  // Stage 0 captures the evaluated function on an input transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld[0] <= 1'b0;
      dat[0] <= '0;
    end else if (rdy[0]) begin
      vld[0] <= in_valid;
      if (in_valid) begin
        dat[0] <= func;
      end
    end
  end

  // Later stages carry the result. Payload is written only when valid data
  // arrives, so a bubble never disturbs the registers behind y.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= 1'b0;
        dat[i] <= '0;
      end
    end else begin
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            dat[i] <= dat[i-1];
          end
        end
      end
    end
  end

`ifdef AOI_PIPE_CNT_EN
  logic [15:0] txn_cnt_q;

  // Completed-transaction counter. It saturates at all-ones and clears only
  // on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_cnt_q <= '0;
    end else if (out_xfer && (txn_cnt_q != 16'hFFFF)) begin
      txn_cnt_q <= txn_cnt_q + 16'd1;
    end
  end

  assign txn_cnt = txn_cnt_q;
`endif

endmodule

// File: tb/tb_aoi_pipe.sv
module tb_aoi_pipe;

  localparam int WIDTH  = 4;
  localparam int STAGES = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, c, d;
  logic [1:0]       mode;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
`ifdef AOI_PIPE_CNT_EN
  logic [15:0]      txn_cnt;
`endif

  aoi_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .mode     (mode),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef AOI_PIPE_CNT_EN
    ,
    .txn_cnt  (txn_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic [1:0] mode;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[10];

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb[$];
  logic             hold_active = 1'b0;
  logic [WIDTH-1:0] hold_y = '0;
  int               n_out = 0;

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] ma, mb, mc, md,
                                             input logic [1:0] mm);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < WIDTH; k++) begin
      case (mm)
        2'b00: r[k] = !((ma[k] && mb[k]) || (mc[k] && md[k]));
        2'b01: r[k] = !((ma[k] || mb[k]) && (mc[k] || md[k]));
        2'b10: r[k] = (ma[k] && mb[k]) || (mc[k] && md[k]);
        default: r[k] = (ma[k] || mb[k]) && (mc[k] || md[k]);
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle. At the negedge it runs the scoreboard and the
  // output-stability check, then it returns #1 after the next posedge.
  task automatic step();
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      hold_active = 1'b0;
    end else begin
      if (hold_active && out_valid) check("y_stable", y, hold_y);
      if (in_valid && in_ready) sb.push_back(model(a, b, c, d, mode));
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else check("sb_order", y, sb.pop_front());
      end
      hold_active = out_valid && !out_ready;
      hold_y      = y;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [3:0] ta, tb_, tc, td, input logic [1:0] tm);
    a = ta; b = tb_; c = tc; d = td; mode = tm;
  endtask

  task automatic rand_ops();
    set_ops(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      step();
      n++;
    end
    check("drain_timeout", (n < 50) ? 1 : 0, 1);
  endtask

  initial begin
    int lat, acc, first, last, gaps, nseen, seen;

    tbl[0] = '{4'hF, 4'hF, 4'h0, 4'h0, 2'b00, 4'h0};
    tbl[1] = '{4'hF, 4'hF, 4'h0, 4'h0, 2'b10, 4'hF};
    tbl[2] = '{4'h5, 4'h0, 4'h0, 4'hA, 2'b01, 4'hF};
    tbl[3] = '{4'h5, 4'hA, 4'h3, 4'hC, 2'b11, 4'hF};
    tbl[4] = '{4'h5, 4'hA, 4'h3, 4'hC, 2'b00, 4'hF};
    tbl[5] = '{4'h5, 4'hA, 4'h3, 4'hC, 2'b10, 4'h0};
    tbl[6] = '{4'h6, 4'h3, 4'h9, 4'hC, 2'b00, 4'h5};
    tbl[7] = '{4'h6, 4'h3, 4'h9, 4'hC, 2'b01, 4'hA};
    tbl[8] = '{4'h6, 4'h3, 4'h9, 4'hC, 2'b11, 4'h5};
    tbl[9] = '{4'h6, 4'h3, 4'h9, 4'hC, 2'b10, 4'hA};

    // Reset held for 2 cycles with in_valid high
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    set_ops(4'hF, 4'hF, 4'h0, 4'h0, 2'b10);
    #1;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_in_ready", in_ready, 0);
`ifdef AOI_PIPE_CNT_EN
    check("rst_txn_cnt", txn_cnt, 0);
`endif
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    check("in_ready_after_rst", in_ready, 1);

    // Truth table, one transaction at a time, with a latency check
    for (int i = 0; i < 10; i++) begin
      set_ops(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].mode);
      in_valid = 1'b1;
      lat = 0;
      do begin
        step();
        in_valid = 1'b0;
        lat++;
      end while (!out_valid && lat < 20);
      check($sformatf("latency_%0d", i), lat, STAGES);
      check($sformatf("truth_%0d", i), y, tbl[i].exp);
      step();
    end

    // Back-pressure: offer 6 transactions with out_ready low
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      in_valid = 1'b1;
      if (in_ready) acc++;
      step();
    end
    check("bp_accepts", acc, STAGES);
    check("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    while (acc < 6) begin
      if (in_ready) begin
        step();
        acc++;
        rand_ops();
      end else begin
        step();
      end
    end
    drain();

    // Throughput: 20 back-to-back transactions
    first = -1; last = -1; gaps = 0; nseen = 0;
    for (int cyc = 0; cyc < 20 + STAGES + 4; cyc++) begin
      in_valid = (cyc < 20);
      rand_ops();
      if (cyc < 20 && !in_ready) gaps++;
      step();
      if (out_valid) begin
        if (first < 0) first = cyc + 1;
        else if (last != cyc) gaps++;
        last = cyc + 1;
        nseen++;
      end
    end
    check("tp_first", first, STAGES);
    check("tp_count", nseen, 20);
    check("tp_gaps", gaps, 0);

    // Mid-flight reset with 2 transactions in the pipe
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_ops();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("mid_rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("mid_rst_no_output", seen, 0);

`ifdef AOI_PIPE_CNT_EN
    check("cnt_cleared", txn_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      in_valid = 1'b1;
      step();
    end
    drain();
    check("cnt_5", txn_cnt, 5);
    force u_dut.txn_cnt_q = 16'hFFFE;
    #1;
    release u_dut.txn_cnt_q;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      in_valid = 1'b1;
      step();
    end
    drain();
    check("cnt_sat", txn_cnt, 16'hFFFF);
`endif

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
